// File: rtl/axis_event_logger.sv
// axis_event_logger: captures {side-band, watched} records whenever the watched vector changes,
// buffers them in an SRAM FIFO and streams them out as fixed-size AXI4-Stream byte packets.
// MODE=0 drops records when full (sticky overflow); MODE=1 freezes capture once full.
// Optional build macro LOGGER_TIMESTAMP_EN replaces the side-band field with a saturating
// cycle delta since the previous capture.
module axis_event_logger #(
  parameter int unsigned SIG_WIDTH   = 20,
  parameter int unsigned IGN_WIDTH   = 12,
  parameter int unsigned FIFO_WIDTH  = 32,
  parameter int unsigned SRAM_BYTES  = 2048,
  parameter int unsigned PACKET_SIZE = 8,
  parameter int unsigned MODE        = 0,
  localparam int unsigned DEPTH      = SRAM_BYTES * 8 / FIFO_WIDTH,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 flush_i,
  input  logic [SIG_WIDTH-1:0] change_i,
  input  logic [IGN_WIDTH-1:0] ignore_i,
  output logic [AW:0]          level_o,
  output logic                 overflow_o,
  output logic                 frozen_o,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tkeep,
  output logic                 m_tlast,
  output logic [7:0]           m_tdata
);

  localparam int unsigned BPR = FIFO_WIDTH / 8;
  localparam int unsigned BW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [AW:0]   FullLevel = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PktLevel  = (AW+1)'(PACKET_SIZE);
  localparam logic [AW:0]   OneLevel  = (AW+1)'(1);
  localparam logic [BW-1:0] LastByte  = BW'(BPR - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StSend} state_e;

  // Capture pipeline
  logic                  en_q, en_d;
  logic [SIG_WIDTH-1:0]  sig_q, sig_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [FIFO_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [FIFO_WIDTH-1:0] record;
  logic                  capture;

  // FIFO bookkeeping
  logic [AW:0]           level_q, level_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  frozen_q, frozen_d;
  logic                  full, wr_en, pop;
  logic [FIFO_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_WIDTH-1:0] rd_data_q;

  // Serialiser
  state_e                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic [BW-1:0]         byte_idx_q, byte_idx_d;
  logic [FIFO_WIDTH-1:0] word_q, word_d;

  // Baseline on enable rising edge, otherwise any watched-bit change.
  assign capture = enable_i && ((change_i != sig_q) || !en_q) && !frozen_q;

`ifdef LOGGER_TIMESTAMP_EN
  logic [IGN_WIDTH-1:0] timer_q, timer_d;
  logic                 unused_ignore;

  assign unused_ignore = ^ignore_i;

  // Delta timer: value at an edge equals edges elapsed since the previous capture edge.
  always_comb begin
    timer_d = timer_q;
    if (capture) begin
      timer_d = IGN_WIDTH'(1);
    end else if (timer_q != {IGN_WIDTH{1'b1}}) begin
      timer_d = timer_q + IGN_WIDTH'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

  assign record = {(en_q ? timer_q : {IGN_WIDTH{1'b0}}), change_i};
`else
  assign record = {ignore_i, change_i};
`endif

  // Capture staging, FIFO pointer/level update and sticky status flags.
  always_comb begin
    en_d       = enable_i;
    sig_d      = change_i;
    wr_pend_d  = capture;
    wr_data_d  = record;
    full       = (level_q == FullLevel);
    // A frozen logger silently discards the one capture already in flight.
    wr_en      = wr_pend_q && !frozen_q && !full;
    overflow_d = overflow_q | (wr_pend_q && !frozen_q && full);
    pop        = (state_q == StLoad);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (wr_en && !pop) begin
      level_d = level_q + OneLevel;
    end else if (!wr_en && pop) begin
      level_d = level_q - OneLevel;
    end
    frozen_d = frozen_q;
    if ((MODE == 1) && wr_en && (level_d == FullLevel)) begin
      frozen_d = 1'b1;
    end
  end

  // Serialiser next-state: IDLE -> FETCH -> LOAD -> SEND (per record).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    pend_d     = pend_q | flush_i;
    unique case (state_q)
      StIdle: begin
        if (level_q >= PktLevel) begin
          state_d = StFetch;
          cnt_d   = PktLevel;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          // level_q < PktLevel here, so it is already the min of the two.
          if (level_q != '0) begin
            state_d = StFetch;
            cnt_d   = level_q;
          end
          pend_d = 1'b0;
        end
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        word_d     = rd_data_q;
        byte_idx_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        if (m_tready) begin
          if (byte_idx_q == LastByte) begin
            if (cnt_q != OneLevel) begin
              cnt_d   = cnt_q - OneLevel;
              state_d = StFetch;
            end else begin
              cnt_d   = '0;
              state_d = StIdle;
            end
          end else begin
            byte_idx_d = byte_idx_q + BW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q       <= 1'b0;
      sig_q      <= '0;
      wr_pend_q  <= 1'b0;
      wr_data_q  <= '0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      frozen_q   <= 1'b0;
      state_q    <= StIdle;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      en_q       <= en_d;
      sig_q      <= sig_d;
      wr_pend_q  <= wr_pend_d;
      wr_data_q  <= wr_data_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      frozen_q   <= frozen_d;
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  // Record SRAM: one write port, registered read port (1-cycle latency).
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data_q;
    rd_data_q <= mem[rd_ptr_q];
  end

  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign frozen_o   = frozen_q;
  assign m_tvalid   = (state_q == StSend);
  assign m_tkeep    = m_tvalid;
  assign m_tlast    = m_tvalid && (cnt_q == OneLevel) && (byte_idx_q == LastByte);
  assign m_tdata    = m_tvalid ? word_q[{byte_idx_q, 3'b000} +: 8] : 8'h00;

endmodule
